// File: rtl/tpu_host_pkg.sv
// Shared types and constants for the TPU frame host: FSM state encoding,
// frame geometry and the pixel-to-bit index mapping.
package tpu_host_pkg;

    localparam int IMG_BITS = 1024;
    localparam int ROW_BITS = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_RESET_TPU = 3'd2,
        ST_ARM       = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    // Row-major bit index into the frame: y*32 + x.
    function automatic logic [9:0] pix_index(input logic [4:0] y, input logic [4:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/tpu_frame_buf.sv
// 32x32 1-bit drawing frame with a single-pixel write port and a
// whole-row clear port; the full frame is presented on one output bus.
module tpu_frame_buf
    import tpu_host_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [4:0]          wr_x,
    input  logic [4:0]          wr_y,
    input  logic                wr_val,
    input  logic                clr_en,
    input  logic [4:0]          clr_row,
    output logic [IMG_BITS-1:0] frame
);

    logic [9:0] row_base;

    assign row_base = {clr_row, 5'd0};

    always_ff @(posedge clk) begin
        if (rst) begin
            frame <= '0;
        end else begin
            if (clr_en) begin
                frame[row_base +: ROW_BITS] <= '0;
            end
            if (wr_en) begin
                frame[pix_index(wr_y, wr_x)] <= wr_val;
            end
        end
    end

endmodule

// File: rtl/tpu_frame_host.sv
// Host-side initiator for the TPU: owns the drawing frame, sequences TPU
// reset/run and latches the result. Macro TPU_HOST_AUTOCLEAR_EN clears the
// frame automatically after a successful capture.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | waiting; pixel writes, clear_req and start_req accepted
// ST_CLEAR     | zeroing one frame row per cycle, rows 0..31
// ST_RESET_TPU | tpu_ena=1, tpu_rst_n=0 for RST_CYCLES cycles
// ST_ARM       | one settling cycle, stale tpu_done ignored
// ST_RUN       | waiting for tpu_done, bounded by TIMEOUT_CYCLES
module tpu_frame_host
    import tpu_host_pkg::*;
#(
    parameter int IMG_W          = 32,
    parameter int IMG_H          = 32,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     iRst,
    input  logic                     pix_wr_en,
    input  logic [4:0]               pix_x,
    input  logic [4:0]               pix_y,
    input  logic                     pix_val,
    input  logic                     clear_req,
    input  logic                     start_req,
    output logic                     busy,
    output logic                     tpu_ena,
    output logic                     tpu_rst_n,
    output logic [IMG_W*IMG_H-1:0]   tpu_image,
    input  logic [3:0]               tpu_num,
    input  logic                     tpu_overflow,
    input  logic                     tpu_done,
    output logic                     result_valid,
    output logic [3:0]               result_num,
    output logic                     result_overflow,
    output logic                     timeout_err
);

    localparam int RST_W = $clog2(RST_CYCLES + 1);

    state_t           state, state_nx;
    logic [4:0]       row_cnt, row_cnt_nx;
    logic [RST_W-1:0] rst_cnt, rst_cnt_nx;
    logic [15:0]      run_cnt, run_cnt_nx;
    logic             valid_nx, ovf_nx, terr_nx;
    logic [3:0]       num_nx;
    logic             buf_wr_en, buf_clr_en;

    always_ff @(posedge clk) begin
        if (iRst) begin
            state           <= ST_IDLE;
            row_cnt         <= '0;
            rst_cnt         <= '0;
            run_cnt         <= '0;
            result_valid    <= 1'b0;
            result_num      <= '0;
            result_overflow <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            state           <= state_nx;
            row_cnt         <= row_cnt_nx;
            rst_cnt         <= rst_cnt_nx;
            run_cnt         <= run_cnt_nx;
            result_valid    <= valid_nx;
            result_num      <= num_nx;
            result_overflow <= ovf_nx;
            timeout_err     <= terr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        row_cnt_nx = row_cnt;
        rst_cnt_nx = rst_cnt;
        run_cnt_nx = run_cnt;
        valid_nx   = result_valid;
        num_nx     = result_num;
        ovf_nx     = result_overflow;
        terr_nx    = timeout_err;
        buf_wr_en  = 1'b0;
        buf_clr_en = 1'b0;

        case (state)
            ST_IDLE: begin
                // Requests pre-empt a same-cycle pixel write, which is dropped.
                if (clear_req) begin
                    state_nx   = ST_CLEAR;
                    row_cnt_nx = '0;
                end else if (start_req) begin
                    state_nx   = ST_RESET_TPU;
                    rst_cnt_nx = '0;
                    valid_nx   = 1'b0;
                    terr_nx    = 1'b0;
                end else begin
                    buf_wr_en  = pix_wr_en;
                end
            end
            ST_CLEAR: begin
                buf_clr_en = 1'b1;
                if (row_cnt == 5'(IMG_H - 1)) begin
                    state_nx = ST_IDLE;
                end else begin
                    row_cnt_nx = row_cnt + 5'd1;
                end
            end
            ST_RESET_TPU: begin
                if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                    state_nx = ST_ARM;
                end else begin
                    rst_cnt_nx = rst_cnt + RST_W'(1);
                end
            end
            ST_ARM: begin
                state_nx   = ST_RUN;
                run_cnt_nx = '0;
            end
            ST_RUN: begin
                if (tpu_done) begin
                    valid_nx = 1'b1;
                    num_nx   = tpu_num;
                    ovf_nx   = tpu_overflow;
`ifdef TPU_HOST_AUTOCLEAR_EN
                    state_nx   = ST_CLEAR;
                    row_cnt_nx = '0;
`else
                    state_nx   = ST_IDLE;
`endif
                end else if (run_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    terr_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end else if (run_cnt != 16'hFFFF) begin
                    run_cnt_nx = run_cnt + 16'd1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign tpu_ena   = (state == ST_RESET_TPU) || (state == ST_ARM) || (state == ST_RUN);
    assign tpu_rst_n = (state != ST_RESET_TPU);

    tpu_frame_buf u_frame_buf (
        .clk     (clk),
        .rst     (iRst),
        .wr_en   (buf_wr_en),
        .wr_x    (pix_x),
        .wr_y    (pix_y),
        .wr_val  (pix_val),
        .clr_en  (buf_clr_en),
        .clr_row (row_cnt),
        .frame   (tpu_image)
    );

endmodule
